// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types, limits, FSM states and Gray phase constants for quad_encoder
package enc_pkg;

  typedef logic signed [15:0] ticks_t;

  localparam ticks_t TICKS_MAX = 16'sh7FFF;
  localparam ticks_t TICKS_MIN = 16'sh8000;

  typedef enum logic [0:0] {INIT = 1'b0, TRACK = 1'b1} quad_state_t;

  localparam logic [1:0] AB00 = 2'b00;
  localparam logic [1:0] AB01 = 2'b01;
  localparam logic [1:0] AB11 = 2'b11;
  localparam logic [1:0] AB10 = 2'b10;

  // Next phase in the forward direction; the reverse of ab is the phase p with gray_next(p) == ab.
  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    case (ab)
      AB00:    gray_next = AB01;
      AB01:    gray_next = AB11;
      AB11:    gray_next = AB10;
      default: gray_next = AB00;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_if.sv
// rtl/quad_encoder_if.sv - encoder pins, control strobes and decoded outputs of quad_encoder
interface quad_encoder_if;
  import enc_pkg::*;

  logic   enc_a;
  logic   enc_b;
  logic   zero;
  logic   err_clr;
  ticks_t count;
  logic   step;
  logic   dir;
  logic   err;
  logic   sat;
  ticks_t vel;
  logic   vel_valid;

  modport master (
    output enc_a, enc_b, zero, err_clr,
    input  count, step, dir, err, sat, vel, vel_valid
  );

  modport slave (
    input  enc_a, enc_b, zero, err_clr,
    output count, step, dir, err, sat, vel, vel_valid
  );

endinterface

// File: rtl/enc_filter.sv
// rtl/enc_filter.sv - per-channel synchroniser and glitch filter for quad_encoder
module enc_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic load,
  output logic synced,
  output logic level
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      // load snaps the level straight to the pin so a resting pin never looks like an edge
      if (load) begin
        level <= synced;
        cnt   <= '0;
      end else if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_encoder.sv
// rtl/quad_encoder.sv - quadrature decoder: filtered 4x decode into a saturating signed position
// Optional macro VELOCITY_EN adds the windowed velocity output (vel, vel_valid).
module quad_encoder
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int VEL_WIN_LOG2 = 10
) (
  input logic           clk,
  input logic           rst,
  quad_encoder_if.slave bus
);
  localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN;
  localparam int IW = $clog2(INIT_CYC + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);
  localparam logic [0:0] S_INIT  = 1'(INIT);
  localparam logic [0:0] S_TRACK = 1'(TRACK);
  localparam ticks_t NEAR_MAX = TICKS_MAX - 16'sd1;
  localparam ticks_t NEAR_MIN = TICKS_MIN + 16'sd1;

  logic [0:0]    state;
  logic [IW-1:0] init_cnt;
  logic          sync_a, sync_b, filt_a, filt_b, load;
  logic [1:0]    prev_ab, cur_ab;
  logic          fwd, rev, bad;
  ticks_t        count_r;
  logic          step_r, dir_r, err_r, sat_r;

  enc_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .raw(bus.enc_a), .load(load), .synced(sync_a), .level(filt_a)
  );

  enc_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .raw(bus.enc_b), .load(load), .synced(sync_b), .level(filt_b)
  );

  always_comb begin
    load   = (state == S_INIT) && (init_cnt == INIT_LAST);
    cur_ab = {filt_a, filt_b};
    fwd    = (state == S_TRACK) && (cur_ab == gray_next(prev_ab));
    rev    = (state == S_TRACK) && (prev_ab == gray_next(cur_ab));
    bad    = (state == S_TRACK) && ((cur_ab ^ prev_ab) == 2'b11);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
      prev_ab  <= 2'b00;
      count_r  <= '0;
      step_r   <= 1'b0;
      dir_r    <= 1'b0;
      err_r    <= 1'b0;
      sat_r    <= 1'b0;
    end else begin
      step_r <= 1'b0;
      if (state == S_INIT) begin
        if (load) begin
          state   <= S_TRACK;
          prev_ab <= {sync_a, sync_b};
        end else begin
          init_cnt <= init_cnt + 1'b1;
        end
      end else begin
        prev_ab <= cur_ab;
      end

      if (fwd) dir_r <= 1'b1;
      if (rev) dir_r <= 1'b0;

      // a step beyond the limit is swallowed: no pulse, sat simply stays set
      if (bus.zero) begin
        count_r <= '0;
        sat_r   <= 1'b0;
      end else if (fwd && count_r != TICKS_MAX) begin
        count_r <= count_r + 16'sd1;
        step_r  <= 1'b1;
        sat_r   <= (count_r == NEAR_MAX);
      end else if (rev && count_r != TICKS_MIN) begin
        count_r <= count_r - 16'sd1;
        step_r  <= 1'b1;
        sat_r   <= (count_r == NEAR_MIN);
      end

      if (bad) err_r <= 1'b1;
      else if (bus.err_clr) err_r <= 1'b0;
    end
  end

  assign bus.count = count_r;
  assign bus.step  = step_r;
  assign bus.dir   = dir_r;
  assign bus.err   = err_r;
  assign bus.sat   = sat_r;

`ifdef VELOCITY_EN
  localparam logic signed [16:0] D_MAX = 17'sd32767;
  localparam logic signed [16:0] D_MIN = -17'sd32768;

  logic [VEL_WIN_LOG2-1:0] win_cnt;
  ticks_t                  snap, vel_r;
  logic                    vv_r;
  logic signed [16:0]      diff;

  assign diff = {count_r[15], count_r} - {snap[15], snap};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      snap    <= '0;
      vel_r   <= '0;
      vv_r    <= 1'b0;
    end else begin
      vv_r <= 1'b0;
      if (state == S_TRACK) begin
        win_cnt <= win_cnt + 1'b1;
        if (&win_cnt) begin
          vv_r  <= 1'b1;
          snap  <= count_r;
          vel_r <= (diff > D_MAX) ? TICKS_MAX :
                   (diff < D_MIN) ? TICKS_MIN : diff[15:0];
        end
      end
      if (bus.zero) snap <= '0;
    end
  end

  assign bus.vel       = vel_r;
  assign bus.vel_valid = vv_r;
`else
  logic unused_vel_win;
  assign unused_vel_win = (VEL_WIN_LOG2 != 0);
  assign bus.vel       = '0;
  assign bus.vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder.sv
// tb/tb_quad_encoder.sv - randomized self-checking bench for quad_encoder against a phase-index model
module tb_quad_encoder;
  import enc_pkg::*;

  localparam int SS  = 2;
  localparam int FL  = 4;
  localparam int LAT = SS + FL + 1;   // edges from pin change (first edge after it = 1) to count update
`ifdef VELOCITY_EN
  localparam int VW = 6;
`else
  localparam int VW = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  quad_encoder_if bus ();

  quad_encoder #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .VEL_WIN_LOG2(VW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: the pins sit at a position 0..3 along the forward cycle 00,01,11,10.
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int m_idx, m_cnt, m_dir, m_err, m_sat, m_steps;
  int steps_seen = 0;
  int vv_seen = 0;

  always @(negedge clk) begin
    if (rst && bus.step) steps_seen++;
    if (rst && bus.vel_valid) vv_seen++;
  end

  task automatic set_pins(input logic [1:0] ab);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
  endtask

  // d = positions moved along the cycle: 1 forward, 3 backward, 2 illegal jump
  task automatic model_apply(input int d, input bit zr, input bit ec, output bit exp_step);
    exp_step = 1'b0;
    if (d == 1 && m_cnt < 32767) begin
      m_cnt++; exp_step = 1'b1; m_sat = (m_cnt == 32767);
    end
    if (d == 3 && m_cnt > -32768) begin
      m_cnt--; exp_step = 1'b1; m_sat = (m_cnt == -32768);
    end
    if (d == 1) m_dir = 1;
    if (d == 3) m_dir = 0;
    if (d == 2) m_err = 1;
    else if (ec) m_err = 0;
    if (zr) begin
      m_cnt = 0; m_sat = 0; exp_step = 1'b0;
    end
    if (exp_step) m_steps++;
  endtask

  task automatic move(input int d, input int hold, input bit lat, input bit zr, input bit ec);
    bit es;
    model_apply(d, zr, ec, es);
    m_idx = (m_idx + d) % 4;
    @(posedge clk); #1;
    set_pins(seq[m_idx]);
    for (int i = 1; i <= hold; i++) begin
      if (i == LAT) begin
        bus.zero = zr;
        bus.err_clr = ec;
      end
      @(posedge clk); #1;
      bus.zero = 1'b0;
      bus.err_clr = 1'b0;
      if (lat && i < LAT) check("lat_early_step", int'(bus.step), 0);
      if (lat && i == LAT) check("lat_step", int'(bus.step), int'(es));
    end
  endtask

  task automatic glitch(input bit ch, input int len);
    logic [1:0] flipped;
    int d;
    bit es;
    flipped = seq[m_idx] ^ (ch ? 2'b01 : 2'b10);
    d = (seq[(m_idx + 1) % 4] == flipped) ? 1 : 3;
    @(posedge clk); #1;
    set_pins(flipped);
    repeat (len) @(posedge clk);
    #1;
    set_pins(seq[m_idx]);
    repeat (LAT + 4) @(posedge clk);
    #1;
    if (len >= FL) begin
      model_apply(d, 1'b0, 1'b0, es);
      model_apply(4 - d, 1'b0, 1'b0, es);
    end
  endtask

  task automatic pulse_zero();
    @(posedge clk); #1 bus.zero = 1'b1;
    @(posedge clk); #1 bus.zero = 1'b0;
    m_cnt = 0; m_sat = 0;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1 bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    m_err = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, int'(bus.count), m_cnt);
    check({tag, "_err"}, int'(bus.err), m_err);
    check({tag, "_sat"}, int'(bus.sat), m_sat);
    check({tag, "_steps"}, steps_seen, m_steps);
  endtask

  task automatic wait_vv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.vel_valid;
    end
    #1;
    if (!ok) check("vel_valid_timeout", 0, 1);
  endtask

  initial begin
    int r;
    int v0;
    bit ok;
    bus.zero = 1'b0;
    bus.err_clr = 1'b0;
    set_pins(2'b11);
    m_idx = 2; m_cnt = 0; m_dir = 0; m_err = 0; m_sat = 0; m_steps = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_count", int'(bus.count), 0);
    check("rst_step", int'(bus.step), 0);
    check("rst_dir", int'(bus.dir), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_sat", int'(bus.sat), 0);
    check("rst_vel", int'(bus.vel), 0);
    check("rst_vel_valid", int'(bus.vel_valid), 0);

    rst = 1'b1;
    bus.zero = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.zero = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_state("init11");

    move(1, 10, 1'b1, 1'b0, 1'b0);
    move(1, 10, 1'b1, 1'b0, 1'b0);
    pulse_zero();
    check_state("zero");

    for (int i = 0; i < 8; i++) move(1, 10, 1'b1, 1'b0, 1'b0);
    check_state("fwd8");
    check("fwd8_dir", int'(bus.dir), 1);

    glitch(1'b0, FL - 1);
    check_state("glitch_short");
    v0 = steps_seen;
    glitch(1'b0, FL);
    check_state("glitch_long");
    check("glitch_long_pulses", steps_seen - v0, 2);

    move(2, 10, 1'b1, 1'b0, 1'b0);
    check_state("illegal");
    pulse_err_clr();
    check_state("err_clr");
    move(3, 10, 1'b1, 1'b0, 1'b0);
    check("rev_dir", int'(bus.dir), 0);
    move(2, 10, 1'b1, 1'b0, 1'b1);
    check_state("err_clr_vs_illegal");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) move(($urandom_range(0, 1) != 0) ? 1 : 3, $urandom_range(LAT + 1, LAT + 7), 1'b1, 1'b0, 1'b0);
      else if (r <= 7) glitch($urandom_range(0, 1) != 0, $urandom_range(1, FL - 1));
      else if (r == 8) move(2, LAT + 2, 1'b0, 1'b0, 1'b0);
      else pulse_err_clr();
      check_state("rnd");
      check("rnd_dir", int'(bus.dir), m_dir);
    end

    @(negedge clk);
    force dut.count_r = 16'sd32766;
    @(posedge clk); #1;
    release dut.count_r;
    m_cnt = 32766; m_sat = 0;
    pulse_err_clr();
    for (int i = 0; i < 3; i++) move(1, 10, 1'b1, 1'b0, 1'b0);
    check_state("sat_hi");
    check("sat_hi_count_lit", int'(bus.count), 32767);
    move(3, 10, 1'b1, 1'b0, 1'b0);
    check_state("sat_away");
    move(1, 10, 1'b1, 1'b1, 1'b0);
    check_state("zero_with_step");

`ifdef VELOCITY_EN
    wait_vv(ok);
    v0 = vv_seen;
    for (int i = 0; i < 5; i++) move(1, 8, 1'b0, 1'b0, 1'b0);
    wait_vv(ok);
    check("vel_5", int'(bus.vel), 5);
    check("vel_valid_once", vv_seen - v0, 1);
    wait_vv(ok);
    check("vel_idle", int'(bus.vel), 0);
`else
    repeat (40) @(posedge clk);
    #1;
    check("vel_off", int'(bus.vel), 0);
    check("vel_valid_off", vv_seen, 0);
`endif

    @(posedge clk); #1;
    m_idx = (m_idx + 1) % 4;
    set_pins(seq[m_idx]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    m_cnt = 0; m_sat = 0; m_err = 0;
    check("midrst_count", int'(bus.count), 0);
    check("midrst_dir", int'(bus.dir), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_state("midrst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
